// File: rtl/sap1_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sap1_control_sequencer
// Purpose  : Ring-counter control sequencer for the SAP-1 datapath. Steps a
//            six-T-state machine cycle (fetch T1-T3, execute T4-T6), decodes
//            the IR opcode nibble and drives the datapath control word.
//            Owns run/idle sequencing and the machine halt condition.
// Ports    : clk        - system clock, rising edge
//            clr_n      - asynchronous active-low reset
//            run        - start/continue request (sampled in IDLE and T6)
//            op_code    - IR[7:4], stable from T4 through T6
//            t_state    - one-hot T1..T6 on bits [0]..[5], zero otherwise
//            cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n
//                       - datapath control word (_n = active low)
//            instr_done - one-cycle pulse during T6
//            halted     - high while in HALT
// Revision : 1.0 - initial release
// ============================================================================
module sap1_control_sequencer #(
  parameter logic [3:0] LDA_OP = 4'h0,
  parameter logic [3:0] SUB_OP = 4'h1,
  parameter logic [3:0] ADD_OP = 4'h2,
  parameter logic [3:0] OUT_OP = 4'hE,
  parameter logic [3:0] HLT_OP = 4'hF
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       run,
  input  logic [3:0] op_code,
  output logic [5:0] t_state,
  output logic       cp,
  output logic       ep,
  output logic       lm_n,
  output logic       ce_n,
  output logic       li_n,
  output logic       ei_n,
  output logic       la_n,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb_n,
  output logic       lo_n,
  output logic       instr_done,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T1   = 4'd1,
    S_T2   = 4'd2,
    S_T3   = 4'd3,
    S_T4   = 4'd4,
    S_T5   = 4'd5,
    S_T6   = 4'd6,
    S_HALT = 4'd7
  } state_e;

  state_e state_q;
  state_e state_d;

  // Opcodes that move a memory operand through MAR at T4.
  logic w_mem_op;
  assign w_mem_op = (op_code == LDA_OP) || (op_code == ADD_OP) ||
                    (op_code == SUB_OP);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = run ? S_T1 : S_IDLE;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = S_T4;
      // HLT is the only instruction that leaves the ring early.
      S_T4:    state_d = (op_code == HLT_OP) ? S_HALT : S_T5;
      S_T5:    state_d = S_T6;
      // Back-to-back instructions: straight from T6 to T1, no dead cycle.
      S_T6:    state_d = run ? S_T1 : S_IDLE;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Control word decode: purely from the registered state and op_code, so an
  // asynchronous clear deactivates every control in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    t_state    = 6'b000000;
    cp         = 1'b0;
    ep         = 1'b0;
    lm_n       = 1'b1;
    ce_n       = 1'b1;
    li_n       = 1'b1;
    ei_n       = 1'b1;
    la_n       = 1'b1;
    ea         = 1'b0;
    su         = 1'b0;
    eu         = 1'b0;
    lb_n       = 1'b1;
    lo_n       = 1'b1;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_T1: begin
        t_state = 6'b000001;
        ep      = 1'b1;
        lm_n    = 1'b0;
      end
      S_T2: begin
        t_state = 6'b000010;
        cp      = 1'b1;
      end
      S_T3: begin
        t_state = 6'b000100;
        ce_n    = 1'b0;
        li_n    = 1'b0;
      end
      S_T4: begin
        t_state = 6'b001000;
        if (w_mem_op) begin
          ei_n = 1'b0;
          lm_n = 1'b0;
        end else if (op_code == OUT_OP) begin
          ea   = 1'b1;
          lo_n = 1'b0;
        end
      end
      S_T5: begin
        t_state = 6'b010000;
        if (op_code == LDA_OP) begin
          ce_n = 1'b0;
          la_n = 1'b0;
        end else if ((op_code == ADD_OP) || (op_code == SUB_OP)) begin
          ce_n = 1'b0;
          lb_n = 1'b0;
        end
      end
      S_T6: begin
        t_state    = 6'b100000;
        instr_done = 1'b1;
        if ((op_code == ADD_OP) || (op_code == SUB_OP)) begin
          eu   = 1'b1;
          la_n = 1'b0;
          su   = (op_code == SUB_OP);
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sap1_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sap1_control_sequencer
// Purpose  : Self-checking bench for sap1_control_sequencer. Table-driven
//            per-cycle vectors plus hand-written halt, async-clear and random
//            opcode sweep sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sap1_control_sequencer;

  logic       clk;
  logic       clr_n;
  logic       run;
  logic [3:0] op_code;
  logic [5:0] t_state;
  logic       cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n;
  logic       instr_done, halted;

  int tests;
  int fails;

  sap1_control_sequencer dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .run        (run),
    .op_code    (op_code),
    .t_state    (t_state),
    .cp         (cp),
    .ep         (ep),
    .lm_n       (lm_n),
    .ce_n       (ce_n),
    .li_n       (li_n),
    .ei_n       (ei_n),
    .la_n       (la_n),
    .ea         (ea),
    .su         (su),
    .eu         (eu),
    .lb_n       (lb_n),
    .lo_n       (lo_n),
    .instr_done (instr_done),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word bit order:
  // cp ep lm_n ce_n li_n ei_n la_n ea su eu lb_n lo_n instr_done halted
  localparam logic [13:0] C_INACT = 14'b00111110001100;
  localparam logic [13:0] C_T1    = 14'b01011110001100;
  localparam logic [13:0] C_T2    = 14'b10111110001100;
  localparam logic [13:0] C_T3    = 14'b00100110001100;
  localparam logic [13:0] C_T4M   = 14'b00011010001100;
  localparam logic [13:0] C_T4O   = 14'b00111111001000;
  localparam logic [13:0] C_T5L   = 14'b00101100001100;
  localparam logic [13:0] C_T5A   = 14'b00101110000100;
  localparam logic [13:0] C_T6ADD = 14'b00111100011110;
  localparam logic [13:0] C_T6SUB = 14'b00111100111110;
  localparam logic [13:0] C_T6O   = 14'b00111110001110;
  localparam logic [13:0] C_HALT  = 14'b00111110001101;

  logic [13:0] w_ctrl;
  assign w_ctrl = {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu,
                   lb_n, lo_n, instr_done, halted};

  typedef struct packed {
    logic        run;
    logic [3:0]  op;
    logic [5:0]  t;
    logic [13:0] c;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] op,
                     input logic [5:0] t, input logic [13:0] c);
    vec_t v;
    v.run = r;
    v.op  = op;
    v.t   = t;
    v.c   = c;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [5:0] exp_t,
                       input logic [13:0] exp_c);
    tests++;
    if ((t_state !== exp_t) || (w_ctrl !== exp_c)) begin
      fails++;
      $display("FAIL %s: t_state=%b ctrl=%b, expected t_state=%b ctrl=%b",
               name, t_state, w_ctrl, exp_t, exp_c);
    end
  endtask

  // At most one bus driver may be active in any cycle.
  always @(negedge clk) begin
    if (clr_n && !$onehot0({ep, ~ce_n, ~ei_n, ea, eu})) begin
      fails++;
      $display("FAIL bus_onehot: drivers ep,ce,ei,ea,eu = %b, expected at most one",
               {ep, ~ce_n, ~ei_n, ea, eu});
    end
  end

  initial begin
    tests   = 0;
    fails   = 0;
    clr_n   = 1'b0;
    run     = 1'b0;
    op_code = 4'h0;

    // ---------------- reset state ----------------
    @(negedge clk);
    @(negedge clk);
    #1 check("reset", 6'b0, C_INACT);

    // ---------------- vector table ----------------
    add(1'b1, 4'h0, 6'b000000, C_INACT);                       // IDLE, run=1
    // LDA
    add(1'b1, 4'h0, 6'b000001, C_T1);
    add(1'b1, 4'h0, 6'b000010, C_T2);
    add(1'b1, 4'h0, 6'b000100, C_T3);
    add(1'b1, 4'h0, 6'b001000, C_T4M);
    add(1'b1, 4'h0, 6'b010000, C_T5L);
    add(1'b1, 4'h0, 6'b100000, C_T6O);
    // ADD, directly after LDA
    add(1'b1, 4'h2, 6'b000001, C_T1);
    add(1'b1, 4'h2, 6'b000010, C_T2);
    add(1'b1, 4'h2, 6'b000100, C_T3);
    add(1'b1, 4'h2, 6'b001000, C_T4M);
    add(1'b1, 4'h2, 6'b010000, C_T5A);
    add(1'b1, 4'h2, 6'b100000, C_T6ADD);
    // SUB
    add(1'b1, 4'h1, 6'b000001, C_T1);
    add(1'b1, 4'h1, 6'b000010, C_T2);
    add(1'b1, 4'h1, 6'b000100, C_T3);
    add(1'b1, 4'h1, 6'b001000, C_T4M);
    add(1'b1, 4'h1, 6'b010000, C_T5A);
    add(1'b1, 4'h1, 6'b100000, C_T6SUB);
    // OUT, run dropped at T6 -> IDLE
    add(1'b1, 4'hE, 6'b000001, C_T1);
    add(1'b1, 4'hE, 6'b000010, C_T2);
    add(1'b1, 4'hE, 6'b000100, C_T3);
    add(1'b1, 4'hE, 6'b001000, C_T4O);
    add(1'b1, 4'hE, 6'b010000, C_INACT);
    add(1'b0, 4'hE, 6'b100000, C_T6O);
    add(1'b0, 4'h7, 6'b000000, C_INACT);                       // IDLE holds
    add(1'b0, 4'h7, 6'b000000, C_INACT);
    add(1'b1, 4'h7, 6'b000000, C_INACT);
    // NOP (opcode 7), run dropped during T3: completes, then IDLE
    add(1'b1, 4'h7, 6'b000001, C_T1);
    add(1'b1, 4'h7, 6'b000010, C_T2);
    add(1'b0, 4'h7, 6'b000100, C_T3);
    add(1'b0, 4'h7, 6'b001000, C_INACT);
    add(1'b0, 4'h7, 6'b010000, C_INACT);
    add(1'b0, 4'h7, 6'b100000, C_T6O);
    add(1'b1, 4'hF, 6'b000000, C_INACT);                       // IDLE, run=1
    // HLT
    add(1'b1, 4'hF, 6'b000001, C_T1);
    add(1'b1, 4'hF, 6'b000010, C_T2);
    add(1'b1, 4'hF, 6'b000100, C_T3);
    add(1'b1, 4'hF, 6'b001000, C_INACT);
    add(1'b1, 4'hF, 6'b000000, C_HALT);

    @(negedge clk);
    clr_n = 1'b1;
    foreach (vecs[i]) begin
      run     = vecs[i].run;
      op_code = vecs[i].op;
      #1 check($sformatf("vec%0d", i), vecs[i].t, vecs[i].c);
      @(negedge clk);
    end

    // ---------------- HALT hold with run toggling ----------------
    for (int i = 0; i < 20; i++) begin
      run     = i[0];
      op_code = 4'(i);
      #1 check($sformatf("halt_hold%0d", i), 6'b0, C_HALT);
      @(negedge clk);
    end
    #2 clr_n = 1'b0;
    #1 check("halt_clear", 6'b0, C_INACT);
    @(negedge clk);
    clr_n = 1'b1;
    run   = 1'b0;
    #1 check("idle_after_halt", 6'b0, C_INACT);

    // ---------------- async clear during ADD T5 ----------------
    @(negedge clk);
    run     = 1'b1;
    op_code = 4'h2;
    repeat (5) @(negedge clk);
    #1 check("add_t5_pre_clr", 6'b010000, C_T5A);
    #2 clr_n = 1'b0;
    #1 check("async_clr_mid_op", 6'b0, C_INACT);
    @(negedge clk);
    clr_n = 1'b1;
    run   = 1'b1;
    #1 check("clr_released_idle", 6'b0, C_INACT);
    @(negedge clk);
    #1 check("first_t1_after_clr", 6'b000001, C_T1);

    // ---------------- random opcode sweep (no HLT) ----------------
    for (int n = 0; n < 1000; n++) begin
      logic ok;
      ok      = 1'b1;
      op_code = 4'($urandom_range(0, 14));
      for (int t = 0; t < 6; t++) begin
        if (t_state !== 6'(1 << t)) ok = 1'b0;
        if (instr_done !== (t == 5)) ok = 1'b0;
        if (su !== ((t == 5) && (op_code == 4'h1))) ok = 1'b0;
        if (!$onehot0({ep, ~ce_n, ~ei_n, ea, eu})) ok = 1'b0;
        @(negedge clk);
        #1;
      end
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL sweep%0d: op=%h sequence wrong, expected T1..T6 ring with done at T6",
                 n, op_code);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sap1_control_sequencer.md
Name: sap1_control_sequencer

Overview:
- Ring-counter control sequencer for the SAP-1 datapath.
- Steps a fixed six-T-state machine cycle: three fetch states T1–T3, then three execute states T4–T6.
- Decodes the 4-bit opcode held in the IR upper nibble.
- Drives the control word for the PC, MAR, RAM, IR, accumulator, ALU, B and output registers.
- Owns run/idle sequencing and the halt condition for the whole machine.

Parameters:
- LDA_OP, 4'h0, opcode for load accumulator.
- SUB_OP, 4'h1, opcode for subtract.
- ADD_OP, 4'h2, opcode for add.
- OUT_OP, 4'hE, opcode for accumulator-to-output.
- HLT_OP, 4'hF, opcode for halt.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr_n  in  1  asynchronous active-low reset.
- run  in  1  start/continue request; sampled in IDLE and at T6.
- op_code  in  4  IR[7:4]; required stable from T4 through T6.
- t_state  out  6  one-hot T1..T6 as bits [0]..[5]; 6'b0 in IDLE and HALT.
- cp  out  1  PC increment.
- ep  out  1  PC enable onto bus.
- lm_n  out  1  MAR load, active low.
- ce_n  out  1  RAM enable onto bus, active low.
- li_n  out  1  IR load, active low.
- ei_n  out  1  IR operand enable onto bus, active low.
- la_n  out  1  accumulator load, active low.
- ea  out  1  accumulator enable onto bus.
- su  out  1  ALU subtract select.
- eu  out  1  ALU enable onto bus.
- lb_n  out  1  B register load, active low.
- lo_n  out  1  output register load, active low.
- instr_done  out  1  one-cycle pulse during T6.
- halted  out  1  high while in HALT.

Behaviour:
- States: IDLE, T1, T2, T3, T4, T5, T6, HALT. State is registered.
- Control outputs are combinational from state and op_code; no glitch-free requirement.
- "Inactive" means active-high signals = 0 and active-low signals = 1.
- Reset (clr_n low, asynchronous): state goes to IDLE immediately, whatever the current state, including mid-instruction or HALT.
  - All controls inactive, t_state = 0, halted = 0, instr_done = 0.
  - Leaving reset: first transition on the first rising edge with clr_n high.
- IDLE: all controls inactive. run = 1 at the edge → T1; otherwise stay in IDLE.
- T1 → T2 → T3 → T4 → T5 unconditionally, one state per cycle. run is ignored in these states.
- T1 (address): ep = 1, lm_n = 0.
- T2 (increment): cp = 1.
- T3 (memory): ce_n = 0, li_n = 0.
- T4, by opcode:
  - LDA, ADD, SUB: ei_n = 0, lm_n = 0.
  - OUT: ea = 1, lo_n = 0.
  - HLT: all controls inactive; next state is HALT, not T5.
  - Any other opcode (3..13): NOP, all controls inactive.
- T5, by opcode:
  - LDA: ce_n = 0, la_n = 0.
  - ADD, SUB: ce_n = 0, lb_n = 0.
  - Others: inactive.
- T6, by opcode:
  - ADD: eu = 1, la_n = 0, su = 0.
  - SUB: eu = 1, la_n = 0, su = 1.
  - Others: inactive.
  - instr_done = 1 for all opcodes.
  - Next state: T1 if run = 1, else IDLE. No dead cycle between back-to-back instructions.
- HALT: entered from T4 only. halted = 1, all controls inactive, t_state = 0. Exit only via clr_n; run has no effect.
- Fixed instruction length: every non-HLT instruction occupies exactly 6 cycles, including NOPs and OUT; there is no early termination.
- Per state, at most one bus driver (ep, ce_n, ei_n, ea, eu) may be asserted; the bench checks this as an assertion.
- su is 0 in every state except SUB at T6.

Test Plan:
- Reset mid-op: assert clr_n low asynchronously during T5 of an ADD → in the same cycle t_state = 0, la_n = lb_n = ce_n = 1, halted = 0. Release with run = 1 → T1 (t_state = 6'b000001, ep = 1, lm_n = 0) on the next edge.
- LDA then ADD, run held high: op_code 0 then 2 → T4 ei_n = lm_n = 0; LDA T5 ce_n = la_n = 0; ADD T5 ce_n = lb_n = 0; ADD T6 eu = 1, la_n = 0, su = 0. instr_done pulses at cycles 6 and 12; the second T1 directly follows the first T6.
- SUB then OUT: op_code 1 → at T6 su = 1, eu = 1, la_n = 0. op_code 14 → at T4 ea = 1, lo_n = 0; T5 and T6 all inactive; total 6 cycles.
- HLT: op_code 15 at T4 → controls inactive; next edge halted = 1, t_state = 0. Hold 20 cycles with run toggling → halted stays 1. clr_n pulse → IDLE, halted = 0.
- run dropped mid-instruction: run = 0 during T3 → instruction completes through T6, then IDLE. run = 1 in IDLE → T1 on the next edge.
- Undefined opcode 4'h7 → T4–T6 all controls inactive, instr_done = 1 at T6. Bus-driver one-hot assertion holds across a random opcode sweep of 1000 instructions.
